// File: rtl/timer_pkg.sv
// Shared timebase definitions for the alarm scheduler.
//   TW             timebase / deadline width in ns
//   NS_PER_TICK    timebase increment per core clock
//   N_CH_DEFAULT   default number of alarm channels
//   ns_after()     wrap-aware "now has reached deadline" test
package timer_pkg;

    localparam int unsigned TW           = 32;
    localparam int unsigned NS_PER_TICK  = 5;
    localparam int unsigned N_CH_DEFAULT = 4;

    // True when now is at or past deadline, assuming they are less than half the range apart.
    function automatic logic ns_after(input logic [TW-1:0] now, input logic [TW-1:0] deadline);
        logic [TW-1:0] diff;
        diff = now - deadline;
        return ~diff[TW-1];
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping. Purely combinational.
//   req      request vector
//   ptr      first index to consider
//   grant_c  one-hot grant
//   idx_c    granted index
//   any_c    some request was granted
module rr_arb #(
    parameter int unsigned N = 4,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant_c,
    output logic [W-1:0] idx_c,
    output logic         any_c
);

    logic [W:0]   cand;
    logic [W-1:0] sel;

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        sel     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (W+1)'(k);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            sel = W'(cand);
            if (!any_c && req[sel]) begin
                any_c        = 1'b1;
                grant_c[sel] = 1'b1;
                idx_c        = sel;
            end
        end
    end

endmodule

// File: rtl/timer_alarm_sched.sv
// One-shot alarm scheduler sharing the free-running ns timebase between N_CH requesters.
// Expired channels are queued as pending and delivered one at a time, round-robin, on a
// valid/ready event port.
//   clk, rst_n                  core clock, async active-low reset
//   now_ns                      current timebase (wraps)
//   arm_valid/arm_ch/arm_delay  arm channel with deadline now_ns + arm_delay
//   cancel_valid/cancel_ch      disarm channel (arm wins on the same channel)
//   exp_valid/exp_ch/exp_ready  expiry event handshake
//   active                      armed, not yet expired
//   pending                     expired, not yet delivered
module timer_alarm_sched
    import timer_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEFAULT,
    parameter int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TW-1:0]   now_ns,
    input  logic            arm_valid,
    input  logic [CH_W-1:0] arm_ch,
    input  logic [TW-1:0]   arm_delay,
    input  logic            cancel_valid,
    input  logic [CH_W-1:0] cancel_ch,
    output logic            exp_valid,
    output logic [CH_W-1:0] exp_ch,
    input  logic            exp_ready,
    output logic [N_CH-1:0] active,
    output logic [N_CH-1:0] pending
);

    logic [TW-1:0]   deadline [N_CH];
    logic [N_CH-1:0] expire_c;
    logic [N_CH-1:0] grant_c;
    logic [CH_W-1:0] pick_c;
    logic            pick_any_c;
    logic            load_c;
    logic [CH_W-1:0] rr_ptr;

    // Per-channel deadline reached this cycle.
    always_comb begin
        expire_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            expire_c[i] = active[i] & ns_after(now_ns, deadline[i]);
        end
    end

    // The output slot may be refilled when empty or being consumed this cycle.
    assign load_c = ~exp_valid | exp_ready;

    rr_arb #(
        .N (N_CH),
        .W (CH_W)
    ) u_arb (
        .req     (pending),
        .ptr     (rr_ptr),
        .grant_c (grant_c),
        .idx_c   (pick_c),
        .any_c   (pick_any_c)
    );

    // Channel state, output slot and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= '0;
            pending   <= '0;
            exp_valid <= 1'b0;
            exp_ch    <= '0;
            rr_ptr    <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                deadline[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (arm_valid && (arm_ch == CH_W'(i))) begin
                    deadline[i] <= now_ns + arm_delay;
                    active[i]   <= 1'b1;
                    pending[i]  <= 1'b0;
                end else if (cancel_valid && (cancel_ch == CH_W'(i))) begin
                    active[i]  <= 1'b0;
                    pending[i] <= 1'b0;
                end else if (expire_c[i]) begin
                    // active and pending are mutually exclusive, so this never races a grant.
                    active[i]  <= 1'b0;
                    pending[i] <= 1'b1;
                end else if (load_c && grant_c[i]) begin
                    pending[i] <= 1'b0;
                end
            end

            if (load_c) begin
                exp_valid <= pick_any_c;
                if (pick_any_c) begin
                    exp_ch <= pick_c;
                    rr_ptr <= (pick_c == CH_W'(N_CH - 1)) ? '0 : pick_c + CH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Self-checking bench for timer_alarm_sched: directed vector table, corner-case sequences and
// randomized traffic against a reference model that tracks time as an unwrapped 64-bit count.
module tb_timer_alarm_sched;

    localparam int N    = 4;
    localparam int STEP = int'(timer_pkg::NS_PER_TICK);

    logic        clk;
    logic        rst_n;
    logic [31:0] now_ns;
    logic        arm_valid;
    logic [1:0]  arm_ch;
    logic [31:0] arm_delay;
    logic        cancel_valid;
    logic [1:0]  cancel_ch;
    logic        exp_valid;
    logic [1:0]  exp_ch;
    logic        exp_ready;
    logic [3:0]  active;
    logic [3:0]  pending;

    timer_alarm_sched #(
        .N_CH (N),
        .CH_W (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .now_ns       (now_ns),
        .arm_valid    (arm_valid),
        .arm_ch       (arm_ch),
        .arm_delay    (arm_delay),
        .cancel_valid (cancel_valid),
        .cancel_ch    (cancel_ch),
        .exp_valid    (exp_valid),
        .exp_ch       (exp_ch),
        .exp_ready    (exp_ready),
        .active       (active),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: unwrapped absolute time, per-channel absolute deadlines.
    longint unsigned abs_t;
    longint unsigned m_dl [N];
    bit [N-1:0]      m_act;
    bit [N-1:0]      m_pend;
    bit              m_valid;
    int              m_ch;
    int              m_ptr;
    logic [31:0]     prev_now;

    typedef struct {
        bit       av;
        int       ach;
        int       adly;
        bit       cv;
        int       cch;
        bit       rdy;
        bit       ev;
        int       ech;
        bit [3:0] act;
        bit [3:0] pend;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_act   = '0;
        m_pend  = '0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_ptr   = 0;
        for (int c = 0; c < N; c++) m_dl[c] = 0;
    endtask

    task automatic idle_inputs();
        arm_valid    = 1'b0;
        arm_ch       = 2'd0;
        arm_delay    = 32'd0;
        cancel_valid = 1'b0;
        cancel_ch    = 2'd0;
    endtask

    task automatic arm(input int ch, input int unsigned dly);
        arm_valid = 1'b1;
        arm_ch    = 2'(ch);
        arm_delay = 32'(dly);
    endtask

    task automatic do_reset(input longint unsigned start);
        rst_n = 1'b0;
        idle_inputs();
        exp_ready = 1'b0;
        model_clear();
        abs_t  = start;
        now_ns = 32'(start);
        #1;
        chk("rst_valid",   64'(exp_valid), 64'd0);
        chk("rst_ch",      64'(exp_ch),    64'd0);
        chk("rst_active",  64'(active),    64'd0);
        chk("rst_pending", 64'(pending),   64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: advance the model with the current inputs, clock the DUT, compare.
    task automatic tick();
        bit         load;
        int         pick;
        int         c;
        bit [N-1:0] n_act;
        bit [N-1:0] n_pend;
        load = !m_valid || exp_ready;
        pick = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (pick < 0 && m_pend[c]) pick = c;
        end
        n_act  = m_act;
        n_pend = m_pend;
        for (int ch = 0; ch < N; ch++) begin
            if (arm_valid && int'(arm_ch) == ch) begin
                m_dl[ch]   = abs_t + 64'(arm_delay);
                n_act[ch]  = 1'b1;
                n_pend[ch] = 1'b0;
            end else if (cancel_valid && int'(cancel_ch) == ch) begin
                n_act[ch]  = 1'b0;
                n_pend[ch] = 1'b0;
            end else if (m_act[ch] && abs_t >= m_dl[ch]) begin
                n_act[ch]  = 1'b0;
                n_pend[ch] = 1'b1;
            end else if (load && pick == ch) begin
                n_pend[ch] = 1'b0;
            end
        end
        prev_now = now_ns;
        @(posedge clk); #1;
        m_act  = n_act;
        m_pend = n_pend;
        if (load) begin
            m_valid = (pick >= 0);
            if (pick >= 0) begin
                m_ch  = pick;
                m_ptr = (pick + 1) % N;
            end
        end
        abs_t  = abs_t + 64'(STEP);
        now_ns = 32'(abs_t);
        chk("mdl_valid",   64'(exp_valid), 64'(m_valid));
        if (m_valid) chk("mdl_ch", 64'(exp_ch), 64'(m_ch));
        chk("mdl_active",  64'(active),    64'(m_act));
        chk("mdl_pending", 64'(pending),   64'(m_pend));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pend_now;
        logic [31:0] ev_now;
        int          events;
        bit          early;
        bit          stable;
        int          order [$];

        rst_n = 1'b1;
        exp_ready = 1'b0;
        idle_inputs();
        abs_t  = 0;
        now_ns = 32'd0;
        model_clear();

        // Directed vectors: expected outputs after each row's clock edge.
        vecs[0]  = '{1'b1, 0, 0,   1'b0, 0, 1'b1, 1'b0, 0, 4'b0001, 4'b0000};
        vecs[1]  = '{1'b1, 1, 0,   1'b0, 0, 1'b1, 1'b0, 0, 4'b0010, 4'b0001};
        vecs[2]  = '{1'b0, 0, 0,   1'b0, 0, 1'b1, 1'b1, 0, 4'b0000, 4'b0010};
        vecs[3]  = '{1'b0, 0, 0,   1'b0, 0, 1'b1, 1'b1, 1, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b1, 3, 100, 1'b0, 0, 1'b1, 1'b0, 0, 4'b1000, 4'b0000};
        vecs[5]  = '{1'b0, 0, 0,   1'b1, 3, 1'b1, 1'b0, 0, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b1, 2, 0,   1'b1, 2, 1'b1, 1'b0, 0, 4'b0100, 4'b0000};
        vecs[7]  = '{1'b0, 0, 0,   1'b0, 0, 1'b0, 1'b0, 0, 4'b0000, 4'b0100};
        vecs[8]  = '{1'b0, 0, 0,   1'b0, 0, 1'b0, 1'b1, 2, 4'b0000, 4'b0000};
        vecs[9]  = '{1'b1, 2, 0,   1'b0, 0, 1'b0, 1'b1, 2, 4'b0100, 4'b0000};
        vecs[10] = '{1'b0, 0, 0,   1'b0, 0, 1'b0, 1'b1, 2, 4'b0000, 4'b0100};
        vecs[11] = '{1'b0, 0, 0,   1'b0, 0, 1'b1, 1'b1, 2, 4'b0000, 4'b0000};
        vecs[12] = '{1'b0, 0, 0,   1'b0, 0, 1'b1, 1'b0, 0, 4'b0000, 4'b0000};

        do_reset(64'd1000);
        for (int i = 0; i < 13; i++) begin
            arm_valid    = vecs[i].av;
            arm_ch       = 2'(vecs[i].ach);
            arm_delay    = 32'(vecs[i].adly);
            cancel_valid = vecs[i].cv;
            cancel_ch    = 2'(vecs[i].cch);
            exp_ready    = vecs[i].rdy;
            tick();
            chk($sformatf("row%0d_valid", i), 64'(exp_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) chk($sformatf("row%0d_ch", i), 64'(exp_ch), 64'(vecs[i].ech));
            chk($sformatf("row%0d_active", i),  64'(active),  64'(vecs[i].act));
            chk($sformatf("row%0d_pending", i), 64'(pending), 64'(vecs[i].pend));
        end
        idle_inputs();

        // Basic latency: arm ch1 for 20 ns at now=100.
        do_reset(64'd100);
        exp_ready = 1'b1;
        arm(1, 20);
        tick();
        idle_inputs();
        pend_now = '1;
        ev_now   = '1;
        for (int k = 0; k < 20 && ev_now == 32'hFFFF_FFFF; k++) begin
            tick();
            if (pending[1] && pend_now == 32'hFFFF_FFFF) pend_now = prev_now;
            if (exp_valid) begin
                ev_now = prev_now;
                chk("s1_ch", 64'(exp_ch), 64'd1);
            end
        end
        chk("s1_pend_now", 64'(pend_now), 64'd120);
        chk("s1_ev_now",   64'(ev_now),   64'd125);

        // Three simultaneous-ish expiries held under backpressure, then drained in RR order.
        do_reset(64'd5000);
        arm(0, 0); tick();
        arm(2, 0); tick();
        arm(3, 0); tick();
        idle_inputs();
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k >= 2 && (!exp_valid || exp_ch != 2'd0)) stable = 1'b0;
        end
        chk("s2_stall_stable", 64'(stable), 64'd1);
        chk("s2_stall_pending", 64'(pending), 64'b1100);
        exp_ready = 1'b1;
        order.delete();
        for (int k = 0; k < 3; k++) begin
            if (exp_valid) order.push_back(int'(exp_ch));
            tick();
        end
        chk("s2_drained", 64'(exp_valid), 64'd0);
        chk("s2_count", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            chk("s2_order0", 64'(order[0]), 64'd0);
            chk("s2_order1", 64'(order[1]), 64'd2);
            chk("s2_order2", 64'(order[2]), 64'd3);
        end

        // Deadline across the 32-bit wrap.
        do_reset(64'h0000_0000_FFFF_FFE0);
        exp_ready = 1'b1;
        arm(2, 50);
        tick();
        idle_inputs();
        pend_now = '1;
        events   = 0;
        early    = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (pending[2] && pend_now == 32'hFFFF_FFFF) pend_now = prev_now;
            if (exp_valid) begin
                events++;
                if (prev_now >= 32'hFFFF_0000) early = 1'b1;
            end
        end
        chk("s3_early",    64'(early),    64'd0);
        chk("s3_pend_now", 64'(pend_now), 64'h12);
        chk("s3_events",   64'(events),   64'd1);

        // Cancel before deadline, then arm+cancel in one cycle.
        do_reset(64'd20000);
        exp_ready = 1'b1;
        arm(3, 100);
        tick();
        idle_inputs();
        for (int k = 0; k < 7; k++) tick();
        cancel_valid = 1'b1;
        cancel_ch    = 2'd3;
        tick();
        idle_inputs();
        events = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (exp_valid) events++;
        end
        chk("s4_no_event", 64'(events),    64'd0);
        chk("s4_inactive", 64'(active[3]), 64'd0);
        arm(3, 100);
        cancel_valid = 1'b1;
        cancel_ch    = 2'd3;
        tick();
        idle_inputs();
        chk("s4_arm_wins", 64'(active[3]), 64'd1);

        // Re-arm before the first deadline: only the second one fires.
        do_reset(64'd30000);
        exp_ready = 1'b1;
        arm(1, 30);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) tick();
        arm(1, 200);
        tick();
        idle_inputs();
        pend_now = '1;
        events   = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (pending[1] && pend_now == 32'hFFFF_FFFF) pend_now = prev_now;
            if (exp_valid) events++;
        end
        chk("s5_events",   64'(events),   64'd1);
        chk("s5_pend_now", 64'(pend_now), 64'd30220);

        // Reset mid-operation with an event held in the slot.
        do_reset(64'd40000);
        arm(0, 0);    tick();
        arm(1, 1000); tick();
        arm(2, 1000); tick();
        arm(3, 1000); tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) tick();
        chk("s6_held", 64'(exp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid",   64'(exp_valid), 64'd0);
        chk("s6_rst_active",  64'(active),    64'd0);
        chk("s6_rst_pending", 64'(pending),   64'd0);
        do_reset(abs_t);
        exp_ready = 1'b1;
        events = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (exp_valid) events++;
        end
        chk("s6_no_event", 64'(events), 64'd0);

        // Randomized traffic against the model.
        do_reset(64'($urandom));
        for (int k = 0; k < 3000; k++) begin
            arm_valid = ($urandom_range(0, 7) == 0);
            arm_ch    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) arm_delay = $urandom & 32'h7FFF_FFFF;
            else                            arm_delay = 32'($urandom_range(0, 300));
            cancel_valid = ($urandom_range(0, 15) == 0);
            cancel_ch    = 2'($urandom_range(0, 3));
            exp_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
